// File: rtl/spram_fifo_ctrl_pkg.sv
// Shared constants and helpers for the spram_fifo front-end controller.
// Holds the skid depth and the wrap-around increment used by the round-robin pointer.
package spram_fifo_ctrl_pkg;

  localparam int SKID_DEPTH = 2;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with bounded burst locking for the shared FIFO write port.
// The grant is combinational; the pointer, lock, owner and burst count are registered.
module rr_lock_arbiter
  import spram_fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4,
  localparam int REQ_W    = $clog2(NUM_REQ),
  localparam int CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  input  logic               full,
  output logic [REQ_W-1:0]   winner,
  output logic [NUM_REQ-1:0] grant
);

  logic [REQ_W-1:0] rr_ptr;
  logic [REQ_W-1:0] owner;
  logic             lock;
  logic [CNT_W-1:0] burst_cnt;

  logic owner_drop;
  logic found;
  int   start_idx;
  int   win_idx;
  int   eff_cnt;

  // A locked owner that lets go of its valid hands the search to the next index this cycle.
  assign owner_drop = lock && !req[owner];
  assign eff_cnt    = owner_drop ? 0 : int'(burst_cnt);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    start_idx = owner_drop ? rr_next(int'(owner), NUM_REQ) : int'(rr_ptr);
    win_idx   = start_idx;
    found     = 1'b0;
    if (lock && req[owner]) begin
      win_idx = int'(owner);
      found   = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[(start_idx + i) % NUM_REQ]) begin
          win_idx = (start_idx + i) % NUM_REQ;
          found   = 1'b1;
        end
      end
    end
  end

  assign winner = REQ_W'(win_idx);

  always_comb begin
    grant = '0;
    if (found) grant[winner] = 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      owner     <= '0;
      lock      <= 1'b0;
      burst_cnt <= '0;
    end else if (!full) begin
      if (owner_drop) begin
        lock      <= 1'b0;
        burst_cnt <= '0;
        rr_ptr    <= REQ_W'(rr_next(int'(owner), NUM_REQ));
      end
      if (accept) begin
        if (eff_cnt + 1 < BURST_LEN) begin
          lock      <= 1'b1;
          owner     <= winner;
          burst_cnt <= CNT_W'(eff_cnt + 1);
        end else begin
          lock      <= 1'b0;
          burst_cnt <= '0;
          rr_ptr    <= REQ_W'(rr_next(int'(winner), NUM_REQ));
        end
      end
    end
  end

endmodule

// File: rtl/spram_fifo_ctrl.sv
// Front-end for the banked single-port-RAM FIFO: arbitrated write port for NUM_REQ
// producers and a 2-entry skid buffer turning the 1-cycle ren/rvalid read into a stream.
module spram_fifo_ctrl
  import spram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4,
  localparam int REQ_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            s_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  output logic [NUM_REQ-1:0]            s_ready,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  input  logic                          m_ready,
  output logic                          fifo_wen,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_full,
  output logic                          fifo_ren,
  input  logic [DATA_WIDTH-1:0]         fifo_rdata,
  input  logic                          fifo_empty,
  input  logic                          fifo_rvalid,
  output logic [REQ_W-1:0]              grant_id,
  output logic                          err_rvalid
);

  // ---------------- write side ----------------
  logic [REQ_W-1:0]   winner;
  logic [NUM_REQ-1:0] grant;
  logic               any_grant;

  rr_lock_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .BURST_LEN (BURST_LEN)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (s_valid),
    .accept (fifo_wen),
    .full   (fifo_full),
    .winner (winner),
    .grant  (grant)
  );

  // grant is only ever set for a requester whose valid is high.
  assign any_grant  = |grant;
  assign s_ready    = fifo_full ? '0 : grant;
  assign fifo_wen   = any_grant && !fifo_full;
  assign fifo_wdata = any_grant ? s_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        grant_id <= '0;
    else if (fifo_wen) grant_id <= winner;
  end

  // ---------------- read side ----------------
  logic [1:0]            occ;
  logic                  inflight;
  logic                  pop;
  logic                  push_ok;
  logic                  wr_slot;
  logic [DATA_WIDTH-1:0] skid [SKID_DEPTH];

  assign pop     = m_valid && m_ready;
  assign m_valid = (occ != 2'd0);
  assign m_data  = m_valid ? skid[0] : '0;

  // Reserve a slot for every read in flight; m_ready feeds ren directly to keep 1 beat/cycle.
  assign fifo_ren = !fifo_empty && ((int'(occ) + int'(inflight) - int'(pop)) < SKID_DEPTH);
  assign push_ok  = fifo_rvalid && inflight && ((int'(occ) < SKID_DEPTH) || pop);
  assign wr_slot  = ((int'(occ) - int'(pop)) != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ        <= '0;
      inflight   <= 1'b0;
      err_rvalid <= 1'b0;
    end else begin
      inflight <= fifo_ren;
      if (fifo_rvalid && !push_ok) err_rvalid <= 1'b1;
      case ({push_ok, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // NOTE: the skid storage is deliberately not reset; m_data is masked by occ instead.
  always_ff @(posedge clk) begin
    if (pop) skid[0] <= skid[1];
    if (push_ok) skid[wr_slot] <= fifo_rdata;
  end

endmodule
